// File: rtl/lv_wdg_scan.sv
// ---------------------------------------------------------------------------
// lv_wdg_scan -- background register-integrity scanner.
//
// Walks the inclusive address window [SCAN_START_ADDR, SCAN_END_ADDR], one
// read every SCAN_INTV idle cycles, through the register access controller's
// watchdog-scan read port. Each returned data word has its CRC recomputed and
// compared with the stored CRC. Mismatches and ack timeouts are reported as
// one-cycle pulses plus sticky flags. An SPI watchdog-reset pulse restarts
// the interval timer, so scans back off while SPI traffic is active.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_scan_en               scan enable (level)
//   i_spi_rst_wdg           pulse, restarts the interval timer
//   i_err_clr               clears sticky flags and o_err_addr
//   o_wdg_scan_rac_rd_req   read request to access controller
//   o_wdg_scan_rac_addr     read address
//   i_rac_wdg_scan_ack      read ack; data/CRC valid in this cycle
//   i_rac_wdg_scan_data     read data
//   i_rac_wdg_scan_crc      stored CRC of the read data
//   o_crc_err_pulse         one-cycle pulse on CRC mismatch
//   o_to_err_pulse          one-cycle pulse on ack timeout
//   o_crc_err_sticky        sticky CRC error flag
//   o_to_err_sticky         sticky timeout flag
//   o_err_addr              address of the most recent error
//   o_scan_wrap             pulse when the address wraps after SCAN_END_ADDR
// ---------------------------------------------------------------------------
module lv_wdg_scan #(
    parameter int unsigned             REG_AW          = 7,
    parameter int unsigned             REG_DW          = 8,
    parameter int unsigned             REG_CRC_W       = 8,
    parameter logic [REG_AW-1:0]       SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0]       SCAN_END_ADDR   = 7'h1F,
    parameter int unsigned             SCAN_INTV       = 256,
    parameter int unsigned             ACK_TO_CYC      = 16,
    parameter logic [REG_CRC_W-1:0]    CRC_POLY        = 8'h07,
    parameter logic [REG_CRC_W-1:0]    CRC_INIT        = 8'hFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    input  logic                 i_spi_rst_wdg,
    input  logic                 i_err_clr,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
    output logic                 o_crc_err_pulse,
    output logic                 o_to_err_pulse,
    output logic                 o_crc_err_sticky,
    output logic                 o_to_err_sticky,
    output logic [REG_AW-1:0]    o_err_addr,
    output logic                 o_scan_wrap
);

    localparam logic [15:0] INTV_LAST = 16'(SCAN_INTV - 1);
    localparam logic [7:0]  TO_LAST   = 8'(ACK_TO_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_CHK
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            intv_q, intv_d;
    logic [7:0]             to_q, to_d;
    logic [REG_AW-1:0]      addr_q, addr_d;
    logic [REG_DW-1:0]      data_q, data_d;
    logic [REG_CRC_W-1:0]   crc_q, crc_d;
    logic                   crc_pulse_q, crc_pulse_d;
    logic                   to_pulse_q, to_pulse_d;
    logic                   crc_sticky_q, crc_sticky_d;
    logic                   to_sticky_q, to_sticky_d;
    logic [REG_AW-1:0]      err_addr_q, err_addr_d;
    logic                   wrap_q, wrap_d;
    logic [REG_AW-1:0]      addr_next;
    logic                   addr_at_end;

    // Bitwise MSB-first CRC, unrolled into a single combinational step.
    function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [REG_DW-1:0] d);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = CRC_INIT;
        for (int unsigned i = 0; i < REG_DW; i++) begin
            fb = c[REG_CRC_W-1] ^ d[REG_DW-1-i];
            c  = {c[REG_CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    assign addr_at_end = (addr_q == SCAN_END_ADDR);
    assign addr_next   = addr_at_end ? SCAN_START_ADDR : addr_q + REG_AW'(1);

    always_comb begin
        state_d      = state_q;
        intv_d       = intv_q;
        to_d         = to_q;
        addr_d       = addr_q;
        data_d       = data_q;
        crc_d        = crc_q;
        crc_pulse_d  = 1'b0;
        to_pulse_d   = 1'b0;
        wrap_d       = 1'b0;
        crc_sticky_d = crc_sticky_q;
        to_sticky_d  = to_sticky_q;
        err_addr_d   = err_addr_q;

        // Clear first so that an error raised below in the same cycle wins.
        if (i_err_clr) begin
            crc_sticky_d = 1'b0;
            to_sticky_d  = 1'b0;
            err_addr_d   = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_scan_en) begin
                    state_d = ST_WAIT;
                    intv_d  = '0;
                end
            end
            ST_WAIT: begin
                if (!i_scan_en) begin
                    state_d = ST_IDLE;
                end else if (i_spi_rst_wdg) begin
                    intv_d = '0;
                end else if (intv_q == INTV_LAST) begin
                    state_d = ST_REQ;
                    to_d    = '0;
                end else begin
                    intv_d = intv_q + 16'd1;
                end
            end
            ST_REQ: begin
                // Enable is ignored here: the transaction always finishes.
                if (i_rac_wdg_scan_ack) begin
                    data_d  = i_rac_wdg_scan_data;
                    crc_d   = i_rac_wdg_scan_crc;
                    state_d = ST_CHK;
                end else if (to_q == TO_LAST) begin
                    to_pulse_d  = 1'b1;
                    to_sticky_d = 1'b1;
                    err_addr_d  = addr_q;
                    addr_d      = addr_next;
                    wrap_d      = addr_at_end;
                    intv_d      = '0;
                    state_d     = i_scan_en ? ST_WAIT : ST_IDLE;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            ST_CHK: begin
                if (crc_calc(data_q) != crc_q) begin
                    crc_pulse_d  = 1'b1;
                    crc_sticky_d = 1'b1;
                    err_addr_d   = addr_q;
                end
                addr_d  = addr_next;
                wrap_d  = addr_at_end;
                intv_d  = '0;
                state_d = i_scan_en ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            intv_q       <= '0;
            to_q         <= '0;
            addr_q       <= SCAN_START_ADDR;
            data_q       <= '0;
            crc_q        <= '0;
            crc_pulse_q  <= 1'b0;
            to_pulse_q   <= 1'b0;
            crc_sticky_q <= 1'b0;
            to_sticky_q  <= 1'b0;
            err_addr_q   <= '0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            intv_q       <= intv_d;
            to_q         <= to_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            crc_q        <= crc_d;
            crc_pulse_q  <= crc_pulse_d;
            to_pulse_q   <= to_pulse_d;
            crc_sticky_q <= crc_sticky_d;
            to_sticky_q  <= to_sticky_d;
            err_addr_q   <= err_addr_d;
            wrap_q       <= wrap_d;
        end
    end

    // Decoded from the state register so reset drops the request at once and
    // the request always falls in the cycle after the ack.
    assign o_wdg_scan_rac_rd_req = (state_q == ST_REQ);
    assign o_wdg_scan_rac_addr   = addr_q;
    assign o_crc_err_pulse       = crc_pulse_q;
    assign o_to_err_pulse        = to_pulse_q;
    assign o_crc_err_sticky      = crc_sticky_q;
    assign o_to_err_sticky       = to_sticky_q;
    assign o_err_addr            = err_addr_q;
    assign o_scan_wrap           = wrap_q;

endmodule

// File: tb/tb_lv_wdg_scan.sv
// ---------------------------------------------------------------------------
// tb_lv_wdg_scan -- directed self-checking bench for lv_wdg_scan.
// Window 0x00..0x02, SCAN_INTV=4, ACK_TO_CYC=16. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// Hand-computed CRC-8 (poly 0x07, init 0xFF, MSB first, no reflect/xorout):
//   data 0x00 -> 0xF3, data 0xFF -> 0x00.
// ---------------------------------------------------------------------------
module tb_lv_wdg_scan;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic       spi_rst;
    logic       err_clr;
    logic       rd_req;
    logic [6:0] addr;
    logic       ack;
    logic [7:0] rdata;
    logic [7:0] rcrc;
    logic       crc_pulse;
    logic       to_pulse;
    logic       crc_sticky;
    logic       to_sticky;
    logic [6:0] err_addr;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    lv_wdg_scan #(
        .REG_AW          (7),
        .REG_DW          (8),
        .REG_CRC_W       (8),
        .SCAN_START_ADDR (7'h00),
        .SCAN_END_ADDR   (7'h02),
        .SCAN_INTV       (4),
        .ACK_TO_CYC      (16),
        .CRC_POLY        (8'h07),
        .CRC_INIT        (8'hFF)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_scan_en             (scan_en),
        .i_spi_rst_wdg         (spi_rst),
        .i_err_clr             (err_clr),
        .o_wdg_scan_rac_rd_req (rd_req),
        .o_wdg_scan_rac_addr   (addr),
        .i_rac_wdg_scan_ack    (ack),
        .i_rac_wdg_scan_data   (rdata),
        .i_rac_wdg_scan_crc    (rcrc),
        .o_crc_err_pulse       (crc_pulse),
        .o_to_err_pulse        (to_pulse),
        .o_crc_err_sticky      (crc_sticky),
        .o_to_err_sticky       (to_sticky),
        .o_err_addr            (err_addr),
        .o_scan_wrap           (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until rd_req is seen high; n = ticks taken, or -1 on budget expiry.
    task automatic wait_req(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (rd_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // With rd_req already high: hold ack low for 'dly' cycles, then ack once.
    task automatic ack_read(input int dly, input logic [7:0] d, input logic [7:0] c);
        repeat (dly) tick();
        ack = 1'b1; rdata = d; rcrc = c;
        tick();
        ack = 1'b0; rdata = '0; rcrc = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scan_en = 1'b0; spi_rst = 1'b0; err_clr = 1'b0;
        ack = 1'b0; rdata = '0; rcrc = '0;
        #3;
        checks++;
        if ({rd_req, crc_pulse, to_pulse, crc_sticky, to_sticky, wrap, err_addr, addr} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b cp=%b tp=%b cs=%b ts=%b wr=%b ea=%h a=%h, exp all 0",
                     rd_req, crc_pulse, to_pulse, crc_sticky, to_sticky, wrap, err_addr, addr);
        end
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_good_read();
        int n;
        scan_en = 1'b1;
        wait_req(20, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL good_first_latency: got %0d exp 5", n); end
        checks++; if (addr !== 7'h00) begin errors++; $display("FAIL good_addr0: got %h exp 00", addr); end
        ack_read(1, 8'h00, 8'hF3);
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL good_req_drop: got %b exp 0", rd_req); end
        tick();
        checks++; if (crc_pulse !== 1'b0 || addr !== 7'h01 || wrap !== 1'b0) begin
            errors++; $display("FAIL good_chk0: got cp=%b a=%h wr=%b exp 0/01/0", crc_pulse, addr, wrap);
        end
        wait_req(20, n);
        checks++; if (n !== 4 || addr !== 7'h01) begin errors++; $display("FAIL good_req1: got n=%0d a=%h exp 4/01", n, addr); end
        ack_read(1, 8'hFF, 8'h00);
        tick();
        checks++; if (crc_pulse !== 1'b0 || addr !== 7'h02) begin
            errors++; $display("FAIL good_chk1: got cp=%b a=%h exp 0/02", crc_pulse, addr);
        end
        wait_req(20, n);
        checks++; if (n !== 4 || addr !== 7'h02) begin errors++; $display("FAIL good_req2: got n=%0d a=%h exp 4/02", n, addr); end
        ack_read(1, 8'h00, 8'hF3);
        tick();
        checks++; if (wrap !== 1'b1 || addr !== 7'h00 || crc_pulse !== 1'b0 || crc_sticky !== 1'b0) begin
            errors++; $display("FAIL good_wrap: got wr=%b a=%h cp=%b cs=%b exp 1/00/0/0", wrap, addr, crc_pulse, crc_sticky);
        end
        tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL good_wrap_pulse: got %b exp 0", wrap); end
    endtask

    task automatic test_crc_mismatch();
        int n;
        wait_req(20, n);
        checks++; if (n !== 3 || addr !== 7'h00) begin errors++; $display("FAIL crc_req0: got n=%0d a=%h exp 3/00", n, addr); end
        ack_read(1, 8'h00, 8'hF3);
        tick();
        wait_req(20, n);
        checks++; if (n !== 4 || addr !== 7'h01) begin errors++; $display("FAIL crc_req1: got n=%0d a=%h exp 4/01", n, addr); end
        ack_read(1, 8'h00, 8'hF2);
        tick();
        checks++; if (crc_pulse !== 1'b1 || crc_sticky !== 1'b1 || err_addr !== 7'h01 || addr !== 7'h02) begin
            errors++; $display("FAIL crc_err: got cp=%b cs=%b ea=%h a=%h exp 1/1/01/02", crc_pulse, crc_sticky, err_addr, addr);
        end
        tick();
        checks++; if (crc_pulse !== 1'b0 || crc_sticky !== 1'b1) begin
            errors++; $display("FAIL crc_pulse_len: got cp=%b cs=%b exp 0/1", crc_pulse, crc_sticky);
        end
    endtask

    task automatic test_timeout();
        int n;
        int high;
        wait_req(20, n);
        checks++; if (n !== 3 || addr !== 7'h02) begin errors++; $display("FAIL to_req: got n=%0d a=%h exp 3/02", n, addr); end
        high = (n > 0) ? 1 : 0;
        for (int i = 0; i < 40 && rd_req === 1'b1; i++) begin
            tick();
            if (rd_req === 1'b1) high++;
        end
        checks++; if (high !== 16) begin errors++; $display("FAIL to_req_len: got %0d cycles exp 16", high); end
        checks++; if (to_pulse !== 1'b1 || to_sticky !== 1'b1 || err_addr !== 7'h02 || addr !== 7'h00 || wrap !== 1'b1) begin
            errors++; $display("FAIL to_err: got tp=%b ts=%b ea=%h a=%h wr=%b exp 1/1/02/00/1", to_pulse, to_sticky, err_addr, addr, wrap);
        end
        tick();
        checks++; if (to_pulse !== 1'b0 || crc_sticky !== 1'b1) begin
            errors++; $display("FAIL to_pulse_len: got tp=%b cs=%b exp 0/1", to_pulse, crc_sticky);
        end
    endtask

    task automatic test_spi_backoff();
        int n;
        wait_req(20, n);
        ack_read(1, 8'h00, 8'hF3);
        tick();                       // CHK -> WAIT count 0, addr 1
        tick(); tick();               // count 2
        spi_rst = 1'b1; tick(); spi_rst = 1'b0;
        tick(); tick(); tick();       // count 3 (terminal)
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL spi_mid: got req=%b exp 0", rd_req); end
        spi_rst = 1'b1; tick(); spi_rst = 1'b0;
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL spi_terminal: got req=%b exp 0", rd_req); end
        wait_req(20, n);
        checks++; if (n !== 4 || addr !== 7'h01) begin errors++; $display("FAIL spi_req: got n=%0d a=%h exp 4/01", n, addr); end
        ack_read(1, 8'h00, 8'hF3);
        tick();                       // addr 2, WAIT count 0
    endtask

    task automatic test_disable_req();
        int n;
        int seen;
        wait_req(20, n);
        checks++; if (n !== 4 || addr !== 7'h02) begin errors++; $display("FAIL dis_req: got n=%0d a=%h exp 4/02", n, addr); end
        scan_en = 1'b0;
        repeat (3) tick();
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL dis_req_hold: got %b exp 1", rd_req); end
        ack = 1'b1; rdata = 8'h00; rcrc = 8'hF2;
        tick();
        ack = 1'b0; rdata = '0; rcrc = '0;
        tick();
        checks++; if (crc_pulse !== 1'b1 || err_addr !== 7'h02 || addr !== 7'h00 || wrap !== 1'b1) begin
            errors++; $display("FAIL dis_chk: got cp=%b ea=%h a=%h wr=%b exp 1/02/00/1", crc_pulse, err_addr, addr, wrap);
        end
        seen = 0;
        repeat (12) begin
            tick();
            if (rd_req !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL dis_idle: got %0d req cycles exp 0", seen); end
        scan_en = 1'b1;
        wait_req(20, n);
        checks++; if (n !== 5 || addr !== 7'h00) begin errors++; $display("FAIL dis_resume: got n=%0d a=%h exp 5/00", n, addr); end
        ack_read(1, 8'h00, 8'hF3);
        tick();                       // addr 1, WAIT count 0
    endtask

    task automatic test_clr_vs_set();
        int n;
        wait_req(20, n);
        checks++; if (n !== 4 || addr !== 7'h01) begin errors++; $display("FAIL clr_req: got n=%0d a=%h exp 4/01", n, addr); end
        ack_read(1, 8'h00, 8'hF2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (crc_sticky !== 1'b1 || to_sticky !== 1'b0 || err_addr !== 7'h01 || crc_pulse !== 1'b1) begin
            errors++; $display("FAIL clr_set_wins: got cs=%b ts=%b ea=%h cp=%b exp 1/0/01/1", crc_sticky, to_sticky, err_addr, crc_pulse);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (crc_sticky !== 1'b0 || err_addr !== 7'h00) begin
            errors++; $display("FAIL clr_only: got cs=%b ea=%h exp 0/00", crc_sticky, err_addr);
        end
    endtask

    task automatic test_reset_mid_req();
        int n;
        wait_req(20, n);
        checks++; if (n !== 3 || addr !== 7'h02) begin errors++; $display("FAIL rst_req: got n=%0d a=%h exp 3/02", n, addr); end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({rd_req, crc_pulse, to_pulse, crc_sticky, to_sticky, wrap, err_addr, addr} !== 19'h0) begin
            errors++;
            $display("FAIL rst_mid_req: got req=%b cp=%b tp=%b cs=%b ts=%b wr=%b ea=%h a=%h, exp all 0",
                     rd_req, crc_pulse, to_pulse, crc_sticky, to_sticky, wrap, err_addr, addr);
        end
        tick();
        scan_en = 1'b0;
        rst_n = 1'b1;
        ack = 1'b1; rdata = 8'h00; rcrc = 8'hF2;
        tick();
        ack = 1'b0; rdata = '0; rcrc = '0;
        tick();
        checks++; if (rd_req !== 1'b0 || crc_pulse !== 1'b0 || crc_sticky !== 1'b0 || addr !== 7'h00) begin
            errors++; $display("FAIL rst_late_ack: got req=%b cp=%b cs=%b a=%h exp 0/0/0/00", rd_req, crc_pulse, crc_sticky, addr);
        end
    endtask

    initial begin
        test_reset();
        test_good_read();
        test_crc_mismatch();
        test_timeout();
        test_spi_backoff();
        test_disable_req();
        test_clr_vs_set();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lv_wdg_scan.md
Name: lv_wdg_scan

Overview:
- Background register-integrity scanner; sits directly upstream of the register access controller on its watchdog-scan read port.
- Periodically walks an inclusive address window and issues one read per step.
- Recomputes the CRC of each returned data word and compares it with the stored CRC; reports mismatches and ack timeouts as pulses plus sticky flags.
- Restarts its interval timer on every SPI-triggered watchdog reset pulse, so scans back off while SPI traffic is active.

Parameters:
- REG_AW, 7, register address width (common LV param set)
- REG_DW, 8, register data width (common LV param set)
- REG_CRC_W, 8, register CRC width (common LV param set)
- SCAN_START_ADDR, 7'h00, first scanned address
- SCAN_END_ADDR, 7'h1F, last scanned address (inclusive); must be >= SCAN_START_ADDR
- SCAN_INTV, 256, idle cycles between reads; range 1..65535
- ACK_TO_CYC, 16, max cycles rd_req may stay high without ack; range 2..255
- CRC_POLY, 8'h07, CRC polynomial without the implicit top bit
- CRC_INIT, 8'hFF, CRC seed

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_scan_en  in  1  scan enable (level)
- i_spi_rst_wdg  in  1  single-cycle pulse; restarts interval timer
- i_err_clr  in  1  clears sticky flags
- o_wdg_scan_rac_rd_req  out  1  read request to access controller
- o_wdg_scan_rac_addr  out  REG_AW  read address
- i_rac_wdg_scan_ack  in  1  read ack; data and CRC valid this cycle
- i_rac_wdg_scan_data  in  REG_DW  read data
- i_rac_wdg_scan_crc  in  REG_CRC_W  stored CRC
- o_crc_err_pulse  out  1  one-cycle pulse on CRC mismatch
- o_to_err_pulse  out  1  one-cycle pulse on ack timeout
- o_crc_err_sticky  out  1  sticky CRC error flag
- o_to_err_sticky  out  1  sticky timeout flag
- o_err_addr  out  REG_AW  address of the most recent error
- o_scan_wrap  out  1  one-cycle pulse after SCAN_END_ADDR completes

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0, except o_wdg_scan_rac_addr = SCAN_START_ADDR. FSM = IDLE, interval counter = 0, timeout counter = 0.
- FSM states: IDLE, WAIT, REQ, CHK.
- IDLE:
  - Enters WAIT when i_scan_en=1; interval counter loads 0.
- WAIT:
  - Counter increments each cycle.
  - Moves to REQ when counter reaches SCAN_INTV-1.
  - An i_spi_rst_wdg pulse in WAIT reloads the counter to 0, and takes priority over reaching the terminal count in the same cycle.
- REQ:
  - o_wdg_scan_rac_rd_req=1 and the address is held stable.
  - Request stays high while the controller defers it for SPI traffic.
  - On the ack cycle: capture data and CRC, drop rd_req on the next cycle, go to CHK.
  - If ack is absent for ACK_TO_CYC cycles: drop rd_req, pulse o_to_err_pulse, set the timeout sticky flag, load o_err_addr, advance the address, go to WAIT.
  - An ack arriving in the same cycle the timeout expires counts as an ack, not a timeout.
- CHK (single cycle):
  - Compute the CRC serially-equivalent over the captured data, MSB first: seed CRC_INIT, CRC_POLY, no reflection, no final XOR. Must be a combinational function, not multi-cycle.
  - On mismatch: pulse o_crc_err_pulse, set the CRC sticky flag, load o_err_addr.
  - Advance the address, go to WAIT with the counter at 0.
- Address advance: +1. If the address was SCAN_END_ADDR, wrap to SCAN_START_ADDR and pulse o_scan_wrap in the same cycle as the advance.
- Handshake: at most one outstanding request. rd_req never rises in the cycle immediately after an ack, so the controller's back-to-back grant mask is honoured.
- Disable: i_scan_en=0 in WAIT or CHK returns the FSM to IDLE next cycle. In REQ, the FSM completes the transaction (ack or timeout) first, then goes to IDLE. The address is retained, so scanning resumes where it stopped.
- i_err_clr clears both sticky flags and o_err_addr. If a new error occurs in the same cycle, the set wins.
- Reset mid-REQ: rd_req drops asynchronously. A late ack after reset is ignored because the FSM is in IDLE.

Test Plan:
1. Good read:
   - Setup: SCAN_INTV=4, start=0x00, end=0x02, en=1; bench acks 1 cycle after req with data=8'h00, crc=8'hF3.
   - Response: req rises after 4 WAIT cycles; no error pulses; addresses 0,1,2 in order; o_scan_wrap pulses after 0x02; next address 0x00.
2. CRC mismatch:
   - Stimulus: ack at address 0x01 with data=8'h00, crc=8'hF2.
   - Response: o_crc_err_pulse one cycle; sticky=1; o_err_addr=0x01; scan continues to 0x02.
3. Timeout:
   - Stimulus: ACK_TO_CYC=16, bench never acks at address 0x02.
   - Response: rd_req high exactly 16 cycles; o_to_err_pulse; o_err_addr=0x02; next address 0x00.
4. SPI back-off:
   - Stimulus: pulse i_spi_rst_wdg at WAIT count 2 of 4, and again simultaneously with terminal count.
   - Response: each pulse restarts the count; req delayed accordingly.
5. Disable during REQ:
   - Stimulus: drop en while req is high; ack 3 cycles later.
   - Response: transaction completes, CRC is checked, then IDLE; re-enable resumes at the next address.
6. Clear vs set, then reset:
   - Stimulus: assert i_err_clr in the same cycle as a new CRC mismatch.
   - Response: sticky flag stays 1.
   - Stimulus: assert reset mid-REQ.
   - Response: all outputs at reset values; address = SCAN_START_ADDR.
